// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and FSM state type for the execute-stage ALU
// and the ALU decoder.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial-product add per step, WIDTH steps.
// Only instantiated when ALU_MUL_EN is defined.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  // Accumulator value after the current step; the top captures it on the last step.
  assign o_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last     = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH - 1);
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with Start/Busy/Done handshake; single-cycle logic ops and
// an optional iterative MUL enabled by the ALU_MUL_EN macro.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  alu_state_e       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] w_comb;
  logic             w_accept;
  logic             w_mul_req;

  always_comb begin
    w_comb = '0;
    case (ALUControl)
      ALU_AND: w_comb = SrcA & SrcB;
      ALU_OR:  w_comb = SrcA | SrcB;
      ALU_SUB: w_comb = SrcA - SrcB;
      ALU_SLT: w_comb = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      // Without the multiplier, MUL completes immediately with a zero result.
      ALU_MUL: w_comb = '0;
      default: w_comb = SrcA + SrcB;
    endcase
  end

  assign w_accept = Start && (r_state != MUL);

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_acc_next;
  logic             w_mul_last;

  assign w_mul_req = (ALUControl == ALU_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_mul_req),
    .i_step     (r_state == MUL),
    .i_a        (SrcA),
    .i_b        (SrcB),
    .o_acc_next (w_acc_next),
    .o_last     (w_mul_last)
  );

  assign Busy = (r_state == MUL);
`else
  assign w_mul_req = 1'b0;
  assign Busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept && w_mul_req) begin
            r_state <= MUL;
          end else if (w_accept) begin
            r_state  <= DONE;
            r_result <= w_comb;
            r_zero   <= (w_comb == '0);
          end else begin
            r_state <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (w_mul_last) begin
            r_state  <= DONE;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Done      = (r_state == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; MUL checks follow ALU_MUL_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] held;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_res"},  ALUResult, 32'h0);
    chk({tag, "_zero"}, {31'b0, Zero}, 32'd1);
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, Done}, 32'd0);
  endtask

  // Single-cycle op: result must be visible with Done one cycle after Start.
  task automatic op1(input string tag, input logic [2:0] code, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    Start = 1'b1; ALUControl = code; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0;
    chk({tag, "_done"}, {31'b0, Done}, 32'd1);
    chk({tag, "_res"},  ALUResult, exp);
    chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, (exp == 32'h0)});
    tick();
    chk({tag, "_done_clr"}, {31'b0, Done}, 32'd0);
    chk({tag, "_held"}, ALUResult, exp);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int lat;
    Start = 1'b1; ALUControl = 3'b101; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"},  lat, 32'd33);
    chk({tag, "_res"},  ALUResult, exp);
    chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, (exp == 32'h0)});
    tick();
    chk({tag, "_done_clr"}, {31'b0, Done}, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");
    tick();
    chk_reset_vals("idle");

    // Back-to-back ADD then SUB: Done stays high across both
    Start = 1'b1; ALUControl = 3'b010; SrcA = 32'h7FFF_FFFF; SrcB = 32'h1;
    tick();
    chk("b2b_add_done", {31'b0, Done}, 32'd1);
    chk("b2b_add_res",  ALUResult, 32'h8000_0000);
    chk("b2b_add_zero", {31'b0, Zero}, 32'd0);
    ALUControl = 3'b100; SrcA = 32'd5; SrcB = 32'd5;
    tick();
    Start = 1'b0;
    chk("b2b_sub_done", {31'b0, Done}, 32'd1);
    chk("b2b_sub_res",  ALUResult, 32'h0);
    chk("b2b_sub_zero", {31'b0, Zero}, 32'd1);
    tick();
    chk("b2b_done_clr", {31'b0, Done}, 32'd0);

    op1("slt_neg", 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h1);
    op1("slt_pos", 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h0);
    op1("and",     3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    op1("code111", 3'b111, 32'd3, 32'd4, 32'd7);
    op1("or",      3'b001, 32'h0000_000A, 32'h0000_0005, 32'h0000_000F);
    op1("code011", 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h0);
    held = 32'h0;

`ifdef ALU_MUL_EN
    // MUL with Start pulses and changing inputs during Busy
    Start = 1'b1; ALUControl = 3'b101; SrcA = 32'h1234_5678; SrcB = 32'd3;
    tick();
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("mul_busy_%0d", i), {31'b0, Busy}, 32'd1);
      chk($sformatf("mul_nodone_%0d", i), {31'b0, Done}, 32'd0);
      chk($sformatf("mul_hold_%0d", i), ALUResult, held);
      Start = ((i % 2) == 0) && (i < 32);
      ALUControl = 3'b010; SrcA = 32'(i); SrcB = 32'hDEAD_0000;
      tick();
    end
    chk("mul_done",   {31'b0, Done}, 32'd1);
    chk("mul_busy_0", {31'b0, Busy}, 32'd0);
    chk("mul_res",    ALUResult, 32'h369D_0368);
    chk("mul_zero",   {31'b0, Zero}, 32'd0);
    tick();
    chk("mul_done_clr", {31'b0, Done}, 32'd0);

    mul_run("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    mul_run("mul_zero", 32'h0, 32'hDEAD_BEEF, 32'h0);
    mul_run("mul_small", 32'd7, 32'd6, 32'd42);

    // Reset at busy cycle 10 discards the partial product
    Start = 1'b1; ALUControl = 3'b101; SrcA = 32'h1234_5678; SrcB = 32'd3;
    tick();
    Start = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    chk("rst_mid_busy", {31'b0, Busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    tick();
    chk_reset_vals("rst_mid_idle");
`else
    // Without the multiplier, code 101 completes in one cycle with zero result
    op1("mul_off", 3'b101, 32'h1234_5678, 32'd3, 32'h0);
    chk("mul_off_busy", {31'b0, Busy}, 32'd0);
    op1("pre_rst_add", 3'b010, 32'd9, 32'd1, 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_mid");
`endif

    op1("post_rst_add", 3'b010, 32'd2, 32'd2, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
